posit_mult_pipe: RTL and testbench

//  Parametrised, pipelined multiplier for decoded (denormalized) posits: sign, scale, fraction, zero, NaR.

---
 rtl/posit_mult_pipe.sv | 117 +++++++++++
 tb/tb_posit_mult_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_pipe.sv
// rtl/posit_mult_pipe.sv - pipelined multiplier for decoded posits with valid/ready back-pressure
`timescale 1ns/1ps
module posit_mult_pipe #(
  parameter int FRAC_W  = 4,
  parameter int SCALE_W = 5,
  parameter int STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [FRAC_W-1:0]   fraction_i1,
  input  logic [FRAC_W-1:0]   fraction_i2,
  input  logic [SCALE_W-1:0]  scale_i1,
  input  logic [SCALE_W-1:0]  scale_i2,
  input  logic                sign_i1,
  input  logic                sign_i2,
  input  logic                zero_i1,
  input  logic                zero_i2,
  input  logic                NaR_i1,
  input  logic                NaR_i2,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [2*FRAC_W:0]   fraction_o,
  output logic [SCALE_W:0]    scale_o,
  output logic                sign_o,
  output logic                zero_o,
  output logic                NaR_o
);

  localparam int PW = 2*FRAC_W + 2;   // raw significand product width
  localparam int FW = 2*FRAC_W + 1;   // normalized fraction width
  localparam int SW = SCALE_W + 1;    // product scale width
  localparam int DW = FW + SW + 3;    // packed stage payload: NaR, zero, sign, scale, fraction

  logic [PW-1:0]     prod;
  logic [FW-1:0]     frac_n;
  logic [SW-1:0]     scale_n;
  logic              sign_n;
  logic              zero_n;
  logic              nar_n;
  logic [DW-1:0]     din;

  logic [DW-1:0]     data [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic              full_tail;

  // Stage-0 arithmetic: exact significand product, one-bit normalization, then special-value override
  always_comb begin
    prod    = PW'({1'b1, fraction_i1}) * PW'({1'b1, fraction_i2});
    scale_n = {scale_i1[SCALE_W-1], scale_i1} + {scale_i2[SCALE_W-1], scale_i2}
            + {{(SW-1){1'b0}}, prod[PW-1]};
    if (prod[PW-1]) begin
      frac_n = prod[PW-2:0];
    end else begin
      frac_n = {prod[PW-3:0], 1'b0};
    end
    sign_n = sign_i1 ^ sign_i2;
    nar_n  = 1'b0;
    zero_n = 1'b0;
    // NaR dominates zero; both specials clear the numeric fields
    if (NaR_i1 | NaR_i2) begin
      nar_n   = 1'b1;
      sign_n  = 1'b0;
      scale_n = '0;
      frac_n  = '0;
    end else if (zero_i1 | zero_i2) begin
      zero_n  = 1'b1;
      sign_n  = 1'b0;
      scale_n = '0;
      frac_n  = '0;
    end
    din = {nar_n, zero_n, sign_n, scale_n, frac_n};
  end

  // Load enables: a stage may load unless it and every stage after it is full while the sink stalls
  always_comb begin
    full_tail = 1'b1;
    ld        = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      full_tail = full_tail & v[k];
      ld[k]     = ready_i | ~full_tail;
    end
  end

  assign ready_o = ld[0];

  // Pipeline registers: valids always advance on load, payload only moves with a valid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0] <= valid_i;
        if (valid_i) begin
          data[0] <= din;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            data[k] <= data[k-1];
          end
        end
      end
    end
  end

  assign valid_o = v[STAGES-1];
  assign {NaR_o, zero_o, sign_o, scale_o, fraction_o} = data[STAGES-1];

endmodule

// File: tb/tb_posit_mult_pipe.sv
// tb/tb_posit_mult_pipe.sv - directed self-checking bench for posit_mult_pipe
`timescale 1ns/1ps
module tb_posit_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance: FRAC_W=4, SCALE_W=5, STAGES=2
  logic       valid_i, ready_o, ready_i, valid_o;
  logic [3:0] f1, f2;
  logic [4:0] s1, s2;
  logic       sg1, sg2, z1, z2, n1, n2;
  logic [8:0] fraction_o;
  logic [5:0] scale_o;
  logic       sign_o, zero_o, nar_o;

  posit_mult_pipe #(.FRAC_W(4), .SCALE_W(5), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .fraction_i1(f1), .fraction_i2(f2), .scale_i1(s1), .scale_i2(s2),
    .sign_i1(sg1), .sign_i2(sg2), .zero_i1(z1), .zero_i2(z2), .NaR_i1(n1), .NaR_i2(n2),
    .valid_o(valid_o), .ready_i(ready_i), .fraction_o(fraction_o), .scale_o(scale_o),
    .sign_o(sign_o), .zero_o(zero_o), .NaR_o(nar_o));

  // narrow instances sharing one input set: FRAC_W=1 with STAGES=1 and STAGES=4
  logic       b_valid, b_ready, b_sg1, b_sg2;
  logic [0:0] b_f1, b_f2;
  logic [4:0] b_s1, b_s2;
  logic       a_rdy, a_vld, a_sg, a_z, a_n;
  logic [2:0] a_fr;
  logic [5:0] a_sc;
  logic       c_rdy, c_vld, c_sg, c_z, c_n;
  logic [2:0] c_fr;
  logic [5:0] c_sc;

  posit_mult_pipe #(.FRAC_W(1), .SCALE_W(5), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .valid_i(b_valid), .ready_o(a_rdy),
    .fraction_i1(b_f1), .fraction_i2(b_f2), .scale_i1(b_s1), .scale_i2(b_s2),
    .sign_i1(b_sg1), .sign_i2(b_sg2), .zero_i1(1'b0), .zero_i2(1'b0), .NaR_i1(1'b0), .NaR_i2(1'b0),
    .valid_o(a_vld), .ready_i(b_ready), .fraction_o(a_fr), .scale_o(a_sc),
    .sign_o(a_sg), .zero_o(a_z), .NaR_o(a_n));

  posit_mult_pipe #(.FRAC_W(1), .SCALE_W(5), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .valid_i(b_valid), .ready_o(c_rdy),
    .fraction_i1(b_f1), .fraction_i2(b_f2), .scale_i1(b_s1), .scale_i2(b_s2),
    .sign_i1(b_sg1), .sign_i2(b_sg2), .zero_i1(1'b0), .zero_i2(1'b0), .NaR_i1(1'b0), .NaR_i2(1'b0),
    .valid_o(c_vld), .ready_i(b_ready), .fraction_o(c_fr), .scale_o(c_sc),
    .sign_o(c_sg), .zero_o(c_z), .NaR_o(c_n));

  // hand-computed stream vectors for FRAC_W=4: s1=i, s2=-2, sign1=i[0], sign2=i[1]
  logic [3:0] tf1 [8] = '{4'd0, 4'd8, 4'd8, 4'd15, 4'd4, 4'd1, 4'd12, 4'd0};
  logic [3:0] tf2 [8] = '{4'd0, 4'd0, 4'd8, 4'd15, 4'd4, 4'd0, 4'd0, 4'd15};
  logic [8:0] ef  [8] = '{9'h000, 9'h100, 9'h040, 9'h1C1, 9'h120, 9'h020, 9'h180, 9'h1E0};
  logic [5:0] es  [8] = '{6'h3E, 6'h3F, 6'd1, 6'd2, 6'd2, 6'd3, 6'd4, 6'd5};
  logic       esg [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  // hand-computed vectors for FRAC_W=1: f1=i[0], f2=i[1], s1=i, s2=1
  logic [2:0] bef [8] = '{3'b000, 3'b100, 3'b100, 3'b001, 3'b000, 3'b100, 3'b100, 3'b001};
  logic [5:0] bes [8] = '{6'd1, 6'd2, 6'd3, 6'd5, 6'd5, 6'd6, 6'd7, 6'd9};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; f1 = '0; f2 = '0; s1 = '0; s2 = '0;
    sg1 = 1'b0; sg2 = 1'b0; z1 = 1'b0; z2 = 1'b0; n1 = 1'b0; n2 = 1'b0;
  endtask

  task automatic drive_vec(input int i);
    logic [2:0] ib;
    ib = 3'(i);
    valid_i = 1'b1; f1 = tf1[i]; f2 = tf2[i]; s1 = 5'(i); s2 = 5'b11110;
    sg1 = ib[0]; sg2 = ib[1]; z1 = 1'b0; z2 = 1'b0; n1 = 1'b0; n2 = 1'b0;
  endtask

  task automatic drive_b(input int i);
    logic [2:0] ib;
    ib = 3'(i);
    b_valid = 1'b1; b_f1 = ib[0]; b_f2 = ib[1]; b_s1 = 5'(i); b_s2 = 5'd1;
    b_sg1 = 1'b0; b_sg2 = 1'b0;
  endtask

  // one operand pair through the main pipe; result expected exactly two cycles after acceptance
  task automatic run_one(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [4:0] c1, input logic [4:0] c2, input logic g1, input logic g2,
                         input logic zz1, input logic zz2, input logic nn1, input logic nn2,
                         input logic [8:0] xf, input logic [5:0] xs, input logic xg,
                         input logic xz, input logic xn);
    valid_i = 1'b1; f1 = a1; f2 = a2; s1 = c1; s2 = c2; sg1 = g1; sg2 = g2;
    z1 = zz1; z2 = zz2; n1 = nn1; n2 = nn2;
    #1 chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    step();
    clear_inputs();
    #1 chk({tag, "_early"}, 32'(valid_o), 32'd0);
    step();
    #1;
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_frac"}, 32'(fraction_o), 32'(xf));
    chk({tag, "_scale"}, 32'(scale_o), 32'(xs));
    chk({tag, "_sign"}, 32'(sign_o), 32'(xg));
    chk({tag, "_zero"}, 32'(zero_o), 32'(xz));
    chk({tag, "_nar"}, 32'(nar_o), 32'(xn));
    step();
    #1 chk({tag, "_drained"}, 32'(valid_o), 32'd0);
  endtask

  // eight vectors through the main pipe, with ready_i fixed high or toggled randomly
  task automatic run_stream(input string tag, input bit rnd);
    int idx_in, idx_out, first_cyc, last_cyc;
    logic stalled;
    logic [17:0] prev;
    idx_in = 0; idx_out = 0; first_cyc = 0; last_cyc = 0; stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx_in < 8) drive_vec(idx_in);
      else clear_inputs();
      #1;
      if (stalled) begin
        chk({tag, "_hold_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_hold_data"}, 32'({nar_o, zero_o, sign_o, scale_o, fraction_o}), 32'(prev));
      end
      if (valid_o && ready_i) begin
        chk({tag, "_frac"}, 32'(fraction_o), 32'(ef[idx_out]));
        chk({tag, "_scale"}, 32'(scale_o), 32'(es[idx_out]));
        chk({tag, "_sign"}, 32'(sign_o), 32'(esg[idx_out]));
        chk({tag, "_flags"}, 32'({zero_o, nar_o}), 32'd0);
        if (idx_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx_out++;
      end
      stalled = valid_o && !ready_i;
      prev = {nar_o, zero_o, sign_o, scale_o, fraction_o};
      if (valid_i && ready_o) idx_in++;
      step();
      if (idx_out == 8) break;
    end
    chk({tag, "_count"}, 32'(idx_out), 32'd8);
    if (!rnd) chk({tag, "_consecutive"}, 32'(last_cyc - first_cyc), 32'd7);
    clear_inputs();
    ready_i = 1'b1;
    step();
    #1 chk({tag, "_no_extra"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    ready_i = 1'b1;
    b_valid = 1'b0; b_ready = 1'b1; b_f1 = '0; b_f2 = '0; b_s1 = '0; b_s2 = '0;
    b_sg1 = 1'b0; b_sg2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'({nar_o, zero_o, sign_o, scale_o, fraction_o}), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;
    step();

    // basic product with a carry out of the significand product
    run_one("t1", 4'b1000, 4'b1000, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
            9'b001000000, 6'd4, 1'b1, 1'b0, 1'b0);
    // scale extremes
    run_one("t2_min", 4'b0000, 4'b0000, 5'b10000, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            9'd0, 6'b100000, 1'b0, 1'b0, 1'b0);
    run_one("t2_max", 4'b1111, 4'b1111, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            9'b111000001, 6'd31, 1'b0, 1'b0, 1'b0);
    // specials: NaR beats zero, zero clears sign
    run_one("t3_nar", 4'd5, 4'd5, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
            9'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    run_one("t3_zero", 4'd3, 4'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
            9'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    run_stream("t4_b2b", 1'b0);
    run_stream("t4_rnd", 1'b1);

    // fill the pipe with the sink stalled, then release
    ready_i = 1'b0;
    drive_vec(0);
    step();
    drive_vec(1);
    step();
    #1 chk("t5_full_ready", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    #1 chk("t5_comb_ready", 32'(ready_o), 32'd1);
    clear_inputs();
    #1;
    chk("t5_out0_frac", 32'(fraction_o), 32'(ef[0]));
    chk("t5_out0_scale", 32'(scale_o), 32'(es[0]));
    step();
    #1;
    chk("t5_out1_valid", 32'(valid_o), 32'd1);
    chk("t5_out1_frac", 32'(fraction_o), 32'(ef[1]));
    chk("t5_out1_scale", 32'(scale_o), 32'(es[1]));
    step();
    #1 chk("t5_empty", 32'(valid_o), 32'd0);

    // reset with two results in flight
    step();
    drive_vec(2);
    step();
    drive_vec(3);
    step();
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("t6_valid_now", 32'(valid_o), 32'd0);
    chk("t6_data_now", 32'({nar_o, zero_o, sign_o, scale_o, fraction_o}), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      #1 chk("t6_no_stale", 32'(valid_o), 32'd0);
    end

    // narrow instances: single product, latency 1 and 4
    b_valid = 1'b1; b_f1 = 1'b1; b_f2 = 1'b1; b_s1 = 5'd1; b_s2 = 5'd2; b_sg1 = 1'b0; b_sg2 = 1'b1;
    step();
    b_valid = 1'b0;
    #1;
    chk("s1_t1_valid", 32'(a_vld), 32'd1);
    chk("s1_t1_data", 32'({a_n, a_z, a_sg, a_sc, a_fr}), 32'({1'b0, 1'b0, 1'b1, 6'd4, 3'b001}));
    chk("s4_t1_early", 32'(c_vld), 32'd0);
    step();
    step();
    #1 chk("s4_t1_early3", 32'(c_vld), 32'd0);
    step();
    #1;
    chk("s4_t1_valid", 32'(c_vld), 32'd1);
    chk("s4_t1_data", 32'({c_n, c_z, c_sg, c_sc, c_fr}), 32'({1'b0, 1'b0, 1'b1, 6'd4, 3'b001}));
    step();

    // narrow instances: eight back-to-back operands
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc < 8) drive_b(cyc);
      else b_valid = 1'b0;
      #1;
      if (cyc >= 1 && cyc <= 8) begin
        chk("s1_b2b_valid", 32'(a_vld), 32'd1);
        chk("s1_b2b_data", 32'({a_sg, a_sc, a_fr}), 32'({1'b0, bes[cyc-1], bef[cyc-1]}));
      end else begin
        chk("s1_b2b_idle", 32'(a_vld), 32'd0);
      end
      if (cyc >= 4 && cyc <= 11) begin
        chk("s4_b2b_valid", 32'(c_vld), 32'd1);
        chk("s4_b2b_data", 32'({c_sg, c_sc, c_fr}), 32'({1'b0, bes[cyc-4], bef[cyc-4]}));
      end else begin
        chk("s4_b2b_idle", 32'(c_vld), 32'd0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
